// File: rtl/fifo_buffer.sv
// First-word-fall-through FIFO with internal wrap-around pointers and occupancy count.
// The head entry is read combinationally; full/empty/almost-full decode from count.
module fifo_buffer #(
  parameter int WIDTH        = 47,
  parameter int ADDR_W       = 2,
  parameter int AFULL_THRESH = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic              i_clr_err,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_THRESH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic              empty, full;
  logic              wr_acc, rd_acc, mem_we;

  always_comb begin
    empty  = (count_reg == '0);
    full   = (count_reg == DEPTH_C);
    rd_acc = i_rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    wr_acc = i_wr_en & (~full | rd_acc);
    mem_we = wr_acc & ~i_flush;

    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      if (rd_acc) rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
      if (wr_acc && !rd_acc)      count_next = count_reg + (ADDR_W + 1)'(1);
      else if (rd_acc && !wr_acc) count_next = count_reg - (ADDR_W + 1)'(1);
    end

    // Set beats clear; a flush cycle raises nothing.
    overflow_next  = (~i_flush & i_wr_en & ~wr_acc) | (overflow_reg  & ~i_clr_err);
    underflow_next = (~i_flush & i_rd_en & ~rd_acc) | (underflow_reg & ~i_clr_err);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_ptr_reg] <= i_wr_data;
  end

  assign o_rd_data     = mem[rd_ptr_reg];
  assign o_empty       = empty;
  assign o_full        = full;
  assign o_almost_full = (count_reg >= AFULL_C);
  assign o_count       = count_reg;
  assign o_overflow    = overflow_reg;
  assign o_underflow   = underflow_reg;

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
- Parametrised first-word-fall-through FIFO. It is the next generation of the fixed 4×47-bit addressed register-file buffer.
- Storage remains a simple register array with combinational read of the head entry.
- Adds internal wrap-around pointers, occupancy tracking, full/empty/almost-full flags, synchronous flush and sticky error flags.
- Sits between a producer and a consumer inside the control datapath, replacing externally managed read/write addresses.

Parameters:
- WIDTH, 47, data word width in bits.
- ADDR_W, 2, log2 of depth; DEPTH = 2**ADDR_W (ADDR_W >= 1).
- AFULL_THRESH, 3, o_almost_full asserts when count >= this value; legal range 1..DEPTH.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_flush  input  1  synchronous clear of pointers/count.
- i_wr_en  input  1  push request.
- i_wr_data  input  WIDTH  push data.
- i_rd_en  input  1  pop request.
- i_clr_err  input  1  synchronous clear of sticky error flags.
- o_rd_data  output  WIDTH  head-of-queue data, combinational from storage.
- o_empty  output  1  count == 0.
- o_full  output  1  count == DEPTH.
- o_almost_full  output  1  count >= AFULL_THRESH.
- o_count  output  ADDR_W+1  current occupancy 0..DEPTH.
- o_overflow  output  1  sticky: push refused.
- o_underflow  output  1  sticky: pop refused.

Behaviour:
- **Reset (i_rst_n low, asynchronous).**
  - wr_ptr = rd_ptr = 0, count = 0.
  - o_empty = 1, o_full = 0, o_almost_full = 0, o_overflow = 0, o_underflow = 0.
  - Storage array is not reset.
  - o_rd_data is don't-care while o_empty = 1.
  - Reset mid-operation discards all contents immediately.
- **Pointers.**
  - ADDR_W bits each, wrapping from DEPTH-1 to 0.
  - count is a separate ADDR_W+1-bit register.
  - All flags decode combinationally from count.
- **Accepted push:** wr_acc = i_wr_en & (~o_full | rd_acc).
  - Effect: mem[wr_ptr] <= i_wr_data, wr_ptr++.
- **Accepted pop:** rd_acc = i_rd_en & ~o_empty.
  - Effect: rd_ptr++.
- **Count update:**
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- **Full plus simultaneous push and pop:** both accepted, count stays DEPTH, no overflow.
- **Empty plus simultaneous push and pop:** push accepted, pop refused, underflow set, count becomes 1.
- **FWFT latency.**
  - Data pushed at edge N appears on o_rd_data and o_empty falls immediately after edge N, when the queue was empty.
  - o_rd_data = mem[rd_ptr] at all times.
- **Flush.**
  - i_flush has priority over push/pop in the same cycle.
  - Effect: pointers and count cleared, concurrent push discarded, no error flags raised by that cycle.
  - Flush does not clear o_overflow/o_underflow.
- **Sticky flags.**
  - o_overflow sets on i_wr_en & ~wr_acc.
  - o_underflow sets on i_rd_en & ~rd_acc.
  - Both hold until i_clr_err or reset.
  - If a set event coincides with i_clr_err, the set wins (flag reads 1 next cycle).
- **Contents on refusal:** a refused push or pop never modifies storage, pointers or count.

Test Plan:
- **Fill/drain:** reset, then push 0x1, 0x2, 0x3, 0x4 on consecutive cycles (defaults).
  - o_almost_full = 1 after the 3rd push; o_full = 1, o_count = 4 after the 4th.
  - Pop 4 times: o_rd_data reads 0x1..0x4 in order, o_empty = 1 at end.
- **FWFT:** from empty, push 0x7AB at edge N.
  - Immediately after N: o_empty = 0, o_rd_data = 0x7AB, o_count = 1, with no pop issued.
- **Wrap-around:** run 10 push/pop pairs, each spaced so count alternates between 1 and 2.
  - Data out matches push order across pointer wrap.
  - o_overflow = 0, o_underflow = 0 throughout.
- **Boundaries:**
  - Full with push+pop of 0x55: count stays 4, head advances, 0x55 is read last, no overflow.
  - Empty with push+pop of 0x66: count = 1, o_underflow = 1, head = 0x66.
- **Errors:**
  - Push when full: o_overflow = 1, contents unchanged.
  - Pulse i_clr_err: flag clears.
  - Push-when-full coincident with i_clr_err: o_overflow stays 1.
- **Flush/reset:**
  - Push 3 words, then assert i_flush together with i_wr_en: o_count = 0, o_empty = 1 next cycle, sticky flags unchanged.
  - Drop i_rst_n asynchronously mid-stream: all outputs take reset values before the next clock edge.
